// File: rtl/seq_alu_if.sv
// Request/completion bundle for seq_alu: operands and op in, results, flags and status out.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 19
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, op, a, b, flush,
    input  in_ready, out_valid, result, result_hi, flags, err, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush,
    output in_ready, out_valid, result, result_hi, flags, err, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: 1-cycle add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op 11 completes at once with err set.
module seq_alu #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             load, c_fin, v_fin;
`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   trial;
  logic             ge;
`endif

  always_comb begin
    b_eff   = bus.op[0] ? ~bus.b : bus.b;
    add_sum = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.op[0]};

    // hi:lo holds partial product above the not-yet-consumed multiplier bits.
    mul_sum = {1'b0, hi_q} + {1'b0, b_q & {WIDTH{lo_q[0]}}};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    // hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    trial = {hi_q, lo_q[WIDTH-1]};
    ge    = (trial >= {1'b0, b_q});
    if (div_q) begin
      step_hi = ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end
`endif

    state_d     = state_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    err_d       = err_q;
    load        = 1'b0;
    c_fin       = 1'b0;
    v_fin       = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    div_d       = div_q;
`endif

    case (state_q)
      StIdle: begin
        // flush blocks a same-cycle accept.
        if (bus.in_valid && !bus.flush) begin
          b_d   = bus.b;
          lo_d  = bus.a;
          hi_d  = '0;
          cnt_d = '0;
          case (bus.op)
            2'b00, 2'b01: begin
              load        = 1'b1;
              result_d    = add_sum[WIDTH-1:0];
              result_hi_d = '0;
              err_d       = 1'b0;
              c_fin       = add_sum[WIDTH];
              v_fin       = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            2'b10: begin
              state_d = StCalc;
`ifdef SEQ_ALU_DIV_EN
              div_d   = 1'b0;
`endif
            end
            default: begin
`ifdef SEQ_ALU_DIV_EN
              if (bus.b == '0) begin
                load        = 1'b1;
                result_d    = '1;
                result_hi_d = bus.a;
                err_d       = 1'b1;
              end else begin
                state_d = StCalc;
                div_d   = 1'b1;
              end
`else
              load        = 1'b1;
              result_d    = '0;
              result_hi_d = '0;
              err_d       = 1'b1;
`endif
            end
          endcase
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            load        = 1'b1;
            result_d    = step_lo;
            result_hi_d = step_hi;
            err_d       = 1'b0;
`ifdef SEQ_ALU_DIV_EN
            v_fin       = !div_q && (step_hi != '0);
`else
            v_fin       = (step_hi != '0);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d     = StDone;
      out_valid_d = 1'b1;
      flags_d     = {result_d[WIDTH-1], (result_d == '0), c_fin, v_fin};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
`ifdef SEQ_ALU_DIV_EN
      div_q       <= div_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=19): directed cases, random ops vs an arithmetic model,
// flush, reset mid-operation and back-to-back requests with in_valid held high.
module tb_seq_alu;
  localparam int unsigned W = 19;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [1:0] LongOp = 2'b11;
`else
  localparam logic [1:0] LongOp = 2'b10;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    logic         err;
    logic [7:0]   lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Results straight from the arithmetic definition of each op.
  function automatic exp_t model(input logic [1:0] op, input longint a, input longint b);
    exp_t   e;
    longint mask = (longint'(1) << W) - 1;
    longint half = longint'(1) << (W - 1);
    longint full, sa, sb, ss;
    logic   c, v;
    e  = '0;
    c  = 1'b0;
    v  = 1'b0;
    sa = (a >= half) ? a - (longint'(1) << W) : a;
    sb = (b >= half) ? b - (longint'(1) << W) : b;
    case (op)
      2'b00: begin
        full  = a + b;
        e.res = full[W-1:0];
        c     = full[W];
        ss    = sa + sb;
        v     = (ss >= half) || (ss < -half);
        e.lat = 8'd1;
      end
      2'b01: begin
        full  = (a - b) & mask;
        e.res = full[W-1:0];
        c     = (a >= b);
        ss    = sa - sb;
        v     = (ss >= half) || (ss < -half);
        e.lat = 8'd1;
      end
      2'b10: begin
        full  = a * b;
        e.res = full[W-1:0];
        full  = full >> W;
        e.hi  = full[W-1:0];
        v     = (e.hi != 0);
        e.lat = 8'(W + 1);
      end
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (b == 0) begin
          e.res = '1;
          full  = a;
          e.hi  = full[W-1:0];
          e.err = 1'b1;
          e.lat = 8'd1;
        end else begin
          full  = a / b;
          e.res = full[W-1:0];
          full  = a % b;
          e.hi  = full[W-1:0];
          e.lat = 8'(W + 1);
        end
`else
        e.err = 1'b1;
        e.lat = 8'd1;
`endif
      end
    endcase
    e.fl = {e.res[W-1], (e.res == 0), c, v};
    return e;
  endfunction

  // Issue one request from idle, wait for completion and check every output.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    int   lat;
    e = model(op, longint'(a), longint'(b));
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 3 * W) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(e.lat));
    check({tag, ".result"}, 64'(bus.result), 64'(e.res));
    check({tag, ".result_hi"}, 64'(bus.result_hi), 64'(e.hi));
    check({tag, ".flags"}, 64'(bus.flags), 64'(e.fl));
    check({tag, ".err"}, 64'(bus.err), 64'(e.err));
    check({tag, ".busy_done"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check({tag, ".pulse_one_cycle"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".idle_again"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
  endtask

  initial begin
    int           npulse, n_acc, n_ov, acc0, acc1;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    exp_t         e0, e1;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    #12;
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.result", 64'(bus.result), 64'd0);
    check("rst.result_hi", 64'(bus.result_hi), 64'd0);
    check("rst.flags", 64'(bus.flags), 64'd0);
    check("rst.err", 64'(bus.err), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 64'(bus.in_ready), 64'd1);

    do_op("add_ovf", 2'b00, 19'h3FFFF, 19'h00001);
    check("add_ovf.const_result", 64'(bus.result), 64'h40000);
    check("add_ovf.const_flags", 64'(bus.flags), 64'b1001);
    do_op("sub_eq", 2'b01, 19'd5, 19'd5);
    check("sub_eq.const_flags", 64'(bus.flags), 64'b0110);
    do_op("mul_1000", 2'b10, 19'd1000, 19'd1000);
    check("mul_1000.const_result", 64'(bus.result), 64'h74240);
    check("mul_1000.const_hi", 64'(bus.result_hi), 64'd1);
    do_op("div_100_7", 2'b11, 19'd100, 19'd7);
    do_op("div_5_0", 2'b11, 19'd5, 19'd0);
    do_op("op11_9_3", 2'b11, 19'd9, 19'd3);
    do_op("mul_max", 2'b10, 19'h7FFFF, 19'h7FFFF);
    do_op("sub_borrow", 2'b01, 19'd0, 19'd1);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 5) == 0) rb = '0;
      if (rop == 2'b11 && $urandom_range(0, 1) == 1) rb = W'($urandom_range(1, 300));
      do_op($sformatf("rand%0d", i), rop, ra, rb);
    end

    // Flush mid-multiply: no completion, previous outputs held.
    do_op("pre_flush", 2'b00, 19'd1, 19'd2);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b10;
    bus.a        = 19'd1000;
    bus.b        = 19'd1000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush.in_ready", 64'(bus.in_ready), 64'd1);
    check("flush.busy", 64'(bus.busy), 64'd0);
    check("flush.result_held", 64'(bus.result), 64'd3);
    check("flush.flags_held", 64'(bus.flags), 64'd0);
    count_pulses(W + 6, npulse);
    check("flush.no_out_valid", 64'(npulse), 64'd0);

    // Flush in idle wins over a simultaneous request.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = 2'b00;
    bus.a        = 19'd5;
    bus.b        = 19'd6;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    check("idle_flush.busy", 64'(bus.busy), 64'd0);
    count_pulses(3, npulse);
    check("idle_flush.no_accept", 64'(npulse), 64'd0);
    check("idle_flush.result_held", 64'(bus.result), 64'd3);

    // Reset in the middle of a long operation.
    do_op("pre_rst", 2'b00, 19'd3, 19'd4);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = LongOp;
    bus.a        = 19'd100;
    bus.b        = 19'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst.result", 64'(bus.result), 64'd0);
    check("mid_rst.flags", 64'(bus.flags), 64'd0);
    check("mid_rst.busy", 64'(bus.busy), 64'd0);
    check("mid_rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst.out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    count_pulses(W + 6, npulse);
    check("mid_rst.no_out_valid", 64'(npulse), 64'd0);

    // in_valid held high across an add then a multiply.
    e0 = model(2'b00, 64'd1234, 64'd4321);
    e1 = model(2'b10, 64'd300, 64'd500);
    n_acc = 0;
    n_ov  = 0;
    acc0  = -1;
    acc1  = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.a        = 19'd1234;
    bus.b        = 19'd4321;
    for (int cyc = 0; cyc < 3 * W; cyc++) begin
      if (bus.out_valid) begin
        if (n_ov == 0) check("b2b.add_result", 64'(bus.result), 64'(e0.res));
        else check("b2b.mul_result", 64'(bus.result), 64'(e1.res));
        n_ov++;
      end
      if (bus.in_valid && bus.in_ready) begin
        n_acc++;
        if (n_acc == 1) acc0 = cyc;
        else acc1 = cyc;
        @(posedge clk);
        #1;
        if (n_acc == 1) begin
          bus.op = 2'b10;
          bus.a  = 19'd300;
          bus.b  = 19'd500;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b.accepts", 64'(n_acc), 64'd2);
    check("b2b.pulses", 64'(n_ov), 64'd2);
    check("b2b.spacing", 64'(acc1 - acc0), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
